lcd_read_fsm: RTL and testbench

Reader side of the character-LCD 4-bit bus: performs one LCD read transaction (RW=1) as two nibble strobes and returns the assembled byte. Reads either the busy flag/address counter (RS=0) or display/CG RAM data (RS=1). Sits beside the write/initialization path in the LCD controller, and is used only after initialization completes. The top level muxes LCD_E/RS/RW and tristates the data nibble using `lcd_drive_en`.

---
 rtl/lcd_read_fsm_if.sv | 26 ++
 rtl/lcd_read_fsm.sv | 213 +++++++++++++++++++++
 tb/tb_lcd_read_fsm.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_read_fsm_if.sv
// Request/response and 4-bit LCD pad signals of the LCD read engine.
// master: controller/pad side; slave: lcd_read_fsm.
interface lcd_read_fsm_if;
    logic       start;
    logic       rs_sel;
    logic       poll;
    logic [3:0] lcd_d_in;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_drive_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       bf;
    logic       busy;

    modport master (
        output start, rs_sel, poll, lcd_d_in,
        input  lcd_e, lcd_rs, lcd_rw, lcd_drive_en, rd_data, rd_valid, bf, busy
    );

    modport slave (
        input  start, rs_sel, poll, lcd_d_in,
        output lcd_e, lcd_rs, lcd_rw, lcd_drive_en, rd_data, rd_valid, bf, busy
    );
endinterface

// File: rtl/lcd_read_fsm.sv
// Character-LCD 4-bit read engine: one RW=1 transaction as two nibble strobes.
// Optional busy-flag polling retries are enabled by defining LCD_READ_POLL_EN.
module lcd_read_fsm #(
    parameter int unsigned T_SU   = 2,
    parameter int unsigned T_EH   = 12,
    parameter int unsigned T_GAP  = 50,
    parameter int unsigned T_HOLD = 2,
    parameter int unsigned T_TURN = 2
) (
    input  logic               clk,
    input  logic               reset,
    lcd_read_fsm_if.slave      bus
);

    localparam int unsigned CNT_W = 8;

    localparam logic [CNT_W-1:0] SU_LAST   = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] EH_LAST   = CNT_W'(T_EH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(T_TURN - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_SETUP = 4'd1,
        S_E_HI1 = 4'd2,
        S_GAP   = 4'd3,
        S_E_HI2 = 4'd4,
        S_HOLD  = 4'd5,
        S_TURN  = 4'd6,
        S_DONE  = 4'd7,
        S_PWAIT = 4'd8
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic             poll_q, poll_d;
    logic [3:0]       nib_hi_q, nib_hi_d;
    logic [3:0]       nib_lo_q, nib_lo_d;
    logic             poll_en;

    logic             lcd_e_q, lcd_e_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic             lcd_rw_q, lcd_rw_d;
    logic             drive_en_q, drive_en_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             bf_q, bf_d;
    logic             busy_q, busy_d;

`ifdef LCD_READ_POLL_EN
    assign poll_en = bus.poll;
`else
    assign poll_en = 1'b0;
`endif

    // State, counter, captured request and outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rs_q       <= 1'b0;
            poll_q     <= 1'b0;
            nib_hi_q   <= '0;
            nib_lo_q   <= '0;
            lcd_e_q    <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_rw_q   <= 1'b0;
            drive_en_q <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            bf_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rs_q       <= rs_d;
            poll_q     <= poll_d;
            nib_hi_q   <= nib_hi_d;
            nib_lo_q   <= nib_lo_d;
            lcd_e_q    <= lcd_e_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_rw_q   <= lcd_rw_d;
            drive_en_q <= drive_en_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            bf_q       <= bf_d;
            busy_q     <= busy_d;
        end
    end

    // Next state: each timed state clears the counter on entry and exits at its last count.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 8'd1;
        rs_d     = rs_q;
        poll_d   = poll_q;
        nib_hi_d = nib_hi_q;
        nib_lo_d = nib_lo_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    state_d = S_SETUP;
                    poll_d  = poll_en;
                    rs_d    = poll_en ? 1'b0 : bus.rs_sel;
                end
            end
            S_SETUP: begin
                if (cnt_q == SU_LAST) begin
                    state_d = S_E_HI1;
                    cnt_d   = '0;
                end
            end
            S_E_HI1: begin
                if (cnt_q == EH_LAST) begin
                    nib_hi_d = bus.lcd_d_in;
                    state_d  = S_GAP;
                    cnt_d    = '0;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_E_HI2;
                    cnt_d   = '0;
                end
            end
            S_E_HI2: begin
                if (cnt_q == EH_LAST) begin
                    nib_lo_d = bus.lcd_d_in;
                    state_d  = (poll_q && nib_hi_q[3]) ? S_PWAIT : S_HOLD;
                    cnt_d    = '0;
                end
            end
            S_PWAIT: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_TURN;
                    cnt_d   = '0;
                end
            end
            S_TURN: begin
                if (cnt_q == TURN_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs decoded from the upcoming state so pins line up with state_q.
    always_comb begin
        lcd_e_d    = 1'b0;
        lcd_rs_d   = 1'b0;
        lcd_rw_d   = 1'b0;
        drive_en_d = 1'b1;
        rd_valid_d = 1'b0;
        busy_d     = 1'b1;
        rd_data_d  = rd_data_q;
        bf_d       = bf_q;
        case (state_d)
            S_IDLE: busy_d = 1'b0;
            S_SETUP, S_GAP, S_HOLD, S_PWAIT: begin
                lcd_rw_d   = 1'b1;
                lcd_rs_d   = rs_d;
                drive_en_d = 1'b0;
            end
            S_E_HI1, S_E_HI2: begin
                lcd_e_d    = 1'b1;
                lcd_rw_d   = 1'b1;
                lcd_rs_d   = rs_d;
                drive_en_d = 1'b0;
            end
            S_TURN: drive_en_d = 1'b0;
            S_DONE: begin
                rd_valid_d = 1'b1;
                rd_data_d  = {nib_hi_q, nib_lo_q};
                if (!rs_q) begin
                    bf_d = nib_hi_q[3];
                end
            end
            default: ;
        endcase
        // A poll retry still reports the busy flag it just read.
        if (state_d == S_PWAIT && state_q == S_E_HI2) begin
            bf_d = nib_hi_q[3];
        end
    end

    assign bus.lcd_e        = lcd_e_q;
    assign bus.lcd_rs       = lcd_rs_q;
    assign bus.lcd_rw       = lcd_rw_q;
    assign bus.lcd_drive_en = drive_en_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.bf           = bf_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_lcd_read_fsm.sv
// Scoreboard bench for lcd_read_fsm: directed reads, expected bytes queued at start,
// checked by a monitor on every rd_valid.
module tb_lcd_read_fsm;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    lcd_read_fsm_if bus ();

    lcd_read_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       bf;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   order_viol = 0;

    // LCD pad model: serves one hi/lo nibble pair per read transaction.
    logic [3:0] hi_tab [4];
    logic [3:0] lo_tab [4];
    logic [1:0] rd_idx = 2'd0;
    logic       phase  = 1'b0;

    assign bus.lcd_d_in = phase ? lo_tab[rd_idx] : hi_tab[rd_idx];

    always @(negedge bus.lcd_e or posedge reset) begin
        if (reset) begin
            phase = 1'b0;
        end else begin
            if (phase) rd_idx = rd_idx + 2'd1;
            phase = ~phase;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic b, input int c);
        exp_t e;
        e.data = d;
        e.bf   = b;
        e.cyc  = c;
        sb_q.push_back(e);
    endtask

    task automatic set_tab(input logic [3:0] h0, input logic [3:0] l0,
                           input logic [3:0] h1, input logic [3:0] l1,
                           input logic [3:0] h2, input logic [3:0] l2);
        hi_tab = '{h0, h1, h2, 4'h0};
        lo_tab = '{l0, l1, l2, 4'h0};
        rd_idx = 2'd0;
        phase  = 1'b0;
    endtask

    // Drives start for one cycle from a falling edge; c is the cycle count at drive time.
    task automatic do_start(input logic rs, input logic pl, output int c);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.rs_sel = rs;
        bus.poll   = pl;
        c = cyc;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.rs_sel = 1'b0;
        bus.poll   = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rd_valid && n < budget);
        if (!bus.rd_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: rd_valid not seen after %0d cycles, required within budget", name, n);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_lcd_e"},    int'(bus.lcd_e),        0);
        check({tag, "_lcd_rs"},   int'(bus.lcd_rs),       0);
        check({tag, "_lcd_rw"},   int'(bus.lcd_rw),       0);
        check({tag, "_drive_en"}, int'(bus.lcd_drive_en), 1);
        check({tag, "_rd_data"},  int'(bus.rd_data),      0);
        check({tag, "_rd_valid"}, int'(bus.rd_valid),     0);
        check({tag, "_bf"},       int'(bus.bf),           0);
        check({tag, "_busy"},     int'(bus.busy),         0);
    endtask

    // Scoreboard monitor: each rd_valid pops one expected read.
    always @(negedge clk) begin
        if (!reset && bus.rd_valid) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rd_valid: got rd_data=0x%0h at cycle %0d, required no read pending",
                         bus.rd_data, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_rd_data", int'(bus.rd_data), int'(e.data));
                check("sb_bf",      int'(bus.bf),      int'(e.bf));
                check("sb_cycle",   cyc,               e.cyc);
            end
        end
    end

    // Strobe timing and bus-ordering monitor.
    int   hi_run = 0;
    int   lo_run = 0;
    logic e_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            hi_run = 0;
            lo_run = 0;
            e_prev = 1'b0;
        end else begin
            if (bus.lcd_e && !bus.lcd_rw) order_viol++;
            if (bus.lcd_drive_en && bus.lcd_rw) order_viol++;
            if (bus.lcd_e && !e_prev) begin
                if (phase) check("e_gap", lo_run, 50);
                hi_run = 0;
            end
            if (!bus.lcd_e && e_prev) begin
                check("e_width", hi_run, 12);
                lo_run = 0;
            end
            if (bus.lcd_e) hi_run++;
            else lo_run++;
            e_prev = bus.lcd_e;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int c2;
        int e_cnt;
        int rw_cnt;
        int rs_cnt;
        int nd_cnt;
        int busy_cnt;
        int n;

        bus.start  = 1'b0;
        bus.rs_sel = 1'b0;
        bus.poll   = 1'b0;
        set_tab(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        // Reset, then a long idle stretch.
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        e_cnt = 0; busy_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.lcd_e) e_cnt++;
            if (bus.busy || bus.rd_valid || !bus.lcd_drive_en) busy_cnt++;
        end
        check("idle_e_cycles", e_cnt, 0);
        check("idle_activity", busy_cnt, 0);

        // RS=0 read returning 0x8/0x5.
        set_tab(4'h8, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0);
        do_start(1'b0, 1'b0, c);
        push_exp(8'h85, 1'b1, c + 81);
        check("busy_after_start", int'(bus.busy), 1);
        e_cnt = 0; rw_cnt = 0; nd_cnt = 0;
        repeat (85) begin
            if (bus.lcd_e) e_cnt++;
            if (bus.lcd_rw) rw_cnt++;
            if (!bus.lcd_drive_en) nd_cnt++;
            @(negedge clk);
        end
        check("rd0_e_cycles", e_cnt, 24);
        check("rd0_rw_cycles", rw_cnt, 78);
        check("rd0_released_cycles", nd_cnt, 80);
        check("rd0_idle_again", int'(bus.busy), 0);

        // RS=1 read returning 0x4/0x1; bf must stay at 1.
        set_tab(4'h4, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
        do_start(1'b1, 1'b0, c);
        push_exp(8'h41, 1'b1, c + 81);
        rs_cnt = 0;
        repeat (85) begin
            if (bus.lcd_rs) rs_cnt++;
            @(negedge clk);
        end
        check("rd1_rs_cycles", rs_cnt, 78);
        check("rd1_bf_held", int'(bus.bf), 1);

        // start during GAP is ignored; start right after DONE is accepted.
        set_tab(4'h2, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0);
        do_start(1'b0, 1'b0, c);
        push_exp(8'h27, 1'b0, c + 81);
        repeat (30) @(negedge clk);
        check("gap_busy", int'(bus.busy), 1);
        bus.start  = 1'b1;
        bus.rs_sel = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.rs_sel = 1'b0;
        wait_valid(100, "wait_rd_gap");
        c2 = cyc;
        set_tab(4'hA, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0);
        do_start(1'b1, 1'b0, c);
        check("b2b_start_cycle", c, c2 + 1);
        push_exp(8'hAC, 1'b0, c2 + 82);
        wait_valid(100, "wait_rd_b2b");
        repeat (3) @(negedge clk);
        check("b2b_rd_data_hold", int'(bus.rd_data), 8'hAC);

        // Reset in the middle of the second E strobe.
        set_tab(4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0);
        do_start(1'b0, 1'b0, c);
        n = 0;
        while (!(phase && bus.lcd_e) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_e_hi2", int'(phase && bus.lcd_e), 1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_vals("midrst");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("midrst_rd_data_after", int'(bus.rd_data), 0);

`ifdef LCD_READ_POLL_EN
        // Poll: BF reads 1, 1, then 0; only the last read reports valid.
        set_tab(4'h8, 4'h1, 4'h8, 4'h2, 4'h0, 4'h3);
        do_start(1'b1, 1'b1, c);
        push_exp(8'h03, 1'b0, c + 333);
        repeat (99) @(negedge clk);
        check("poll_bf_mid", int'(bus.bf), 1);
        check("poll_busy_mid", int'(bus.busy), 1);
        check("poll_rw_mid", int'(bus.lcd_rw), 1);
        wait_valid(400, "wait_poll");
        check("poll_reads", int'(rd_idx), 3);
        repeat (3) @(negedge clk);
        check("poll_bf_end", int'(bus.bf), 0);
`else
        // poll is ignored: a single RS=1 read.
        set_tab(4'h8, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
        do_start(1'b1, 1'b1, c);
        push_exp(8'h81, 1'b0, c + 81);
        wait_valid(100, "wait_nopoll");
        repeat (3) @(negedge clk);
        check("nopoll_reads", int'(rd_idx), 1);
        check("nopoll_bf", int'(bus.bf), 0);
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        check("order_violations", order_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
